// File: rtl/ack_bus_arbiter_rr.sv
// ---------------------------------------------------------------------------
// ack_bus_arbiter_rr
//
// Purpose:
//   Arbitrates a shared acknowledge bus between NUM_SRC sources. It supports
//   two policies: round-robin (RR_MODE = 1) or fixed priority with index 0
//   highest (RR_MODE = 0). A grant lasts until one of three things happens:
//   the granted source pulses ack_done, the source withdraws its request, or
//   the grant reaches TIMEOUT cycles. A release always leaves at least one
//   idle cycle before the next grant.
//
// Ports:
//   clk          input             rising-edge clock
//   rst_n        input             asynchronous active-low reset
//   req          input  [NUM_SRC]  per-source request, held until granted
//   ack_done     input             end-of-transfer pulse from granted source
//   grant        output [NUM_SRC]  registered one-hot grant
//   grant_valid  output            OR of all grant bits
//   winner_id    output [ID_W]     index of the granted source (last value
//                                  is retained after release)
//   timeout_err  output            one-cycle pulse after a forced release
// ---------------------------------------------------------------------------
module ack_bus_arbiter_rr #(
  parameter int NUM_SRC = 4,
  parameter int ID_W    = 2,
  parameter int RR_MODE = 1,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] req,
  input  logic               ack_done,
  output logic [NUM_SRC-1:0] grant,
  output logic               grant_valid,
  output logic [ID_W-1:0]    winner_id,
  output logic               timeout_err
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_SRC-1:0] grant_q, grant_d;
  logic [ID_W-1:0]    winner_q, winner_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               terr_q, terr_d;

  logic               pick_found;
  logic [ID_W-1:0]    pick_idx;
  logic [ID_W-1:0]    cand;
  logic               winner_req;
  logic               timeout_hit;
  logic               release_c;
  logic               forced_c;
  logic [ID_W-1:0]    next_ptr;

  // Winner search. In round-robin mode the scan starts at rr_ptr and wraps
  // modulo NUM_SRC; in fixed mode it starts at index 0. rr_ptr never holds a
  // value at or above NUM_SRC, so the modulo keeps every candidate in range.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (RR_MODE != 0) begin
        cand = ID_W'((int'(rr_ptr_q) + k) % NUM_SRC);
      end else begin
        cand = ID_W'(k);
      end
      if (!pick_found && req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Release conditions in GRANT. ack_done has priority over the timeout, so
  // a forced release is reported only when neither ack_done nor a withdrawal
  // explains the release.
  always_comb begin
    winner_req  = req[winner_q];
    timeout_hit = (cnt_q == 8'(TIMEOUT - 1));
    release_c   = (state_q == GRANT) && (ack_done || !winner_req || timeout_hit);
    forced_c    = (state_q == GRANT) && !ack_done && winner_req && timeout_hit;
    next_ptr    = (winner_q == ID_W'(NUM_SRC - 1)) ? '0 : winner_q + 1'b1;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_found) state_d = GRANT;
      GRANT:   if (release_c)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath next values. The grant is built one-hot from the
  // search result. During GRANT everything is held until a release.
  always_comb begin
    grant_d  = grant_q;
    winner_d = winner_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    terr_d   = 1'b0;
    case (state_q)
      IDLE: begin
        grant_d = '0;
        if (pick_found) begin
          grant_d[pick_idx] = 1'b1;
          winner_d          = pick_idx;
          cnt_d             = 8'd0;
        end
      end
      GRANT: begin
        if (release_c) begin
          grant_d  = '0;
          rr_ptr_d = next_ptr;
          cnt_d    = 8'd0;
          terr_d   = forced_c;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        grant_d = '0;
      end
    endcase
  end

  // Output and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q  <= '0;
      winner_q <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= 8'd0;
      terr_q   <= 1'b0;
    end else begin
      grant_q  <= grant_d;
      winner_q <= winner_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      terr_q   <= terr_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = |grant_q;
  assign winner_id   = winner_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_ack_bus_arbiter_rr.sv
// ---------------------------------------------------------------------------
// tb_ack_bus_arbiter_rr
//
// Directed bench for ack_bus_arbiter_rr. Two instances share clock and
// reset: dutFp runs fixed priority with the default timeout, dutRr runs
// round-robin with TIMEOUT = 4 so forced releases are reached quickly.
// Inputs change 1 ns after each rising edge and outputs are sampled there.
// ---------------------------------------------------------------------------
module tb_ack_bus_arbiter_rr;

   logic       clk;
   logic       rst_n;

   logic [3:0] reqFp;
   logic       ackFp;
   logic [3:0] grantFp;
   logic       grantValidFp;
   logic [1:0] winnerFp;
   logic       timeoutErrFp;

   logic [3:0] reqRr;
   logic       ackRr;
   logic [3:0] grantRr;
   logic       grantValidRr;
   logic [1:0] winnerRr;
   logic       timeoutErrRr;

   int checks;
   int failures;

   ack_bus_arbiter_rr #(
      .NUM_SRC(4), .ID_W(2), .RR_MODE(0), .TIMEOUT(16)
   ) dutFp (
      .clk(clk), .rst_n(rst_n), .req(reqFp), .ack_done(ackFp),
      .grant(grantFp), .grant_valid(grantValidFp),
      .winner_id(winnerFp), .timeout_err(timeoutErrFp)
   );

   ack_bus_arbiter_rr #(
      .NUM_SRC(4), .ID_W(2), .RR_MODE(1), .TIMEOUT(4)
   ) dutRr (
      .clk(clk), .rst_n(rst_n), .req(reqRr), .ack_done(ackRr),
      .grant(grantRr), .grant_valid(grantValidRr),
      .winner_id(winnerRr), .timeout_err(timeoutErrRr)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Drive both instances' inputs in one place.
   task automatic applyStimulus(input logic [3:0] fpReq, input logic fpAck,
                                input logic [3:0] rrReq, input logic rrAck);
      reqFp = fpReq;
      ackFp = fpAck;
      reqRr = rrReq;
      ackRr = rrAck;
   endtask

   // Advance to 1 ns past the next rising edge.
   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   // Single comparison point; counts every check and every failure.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Compare every output of the round-robin instance.
   task automatic checkRr(input string tag, input logic [3:0] expGrant,
                          input logic [1:0] expWinner, input logic expTerr);
      checkOutput({tag, ".grant"}, 32'(grantRr), 32'(expGrant));
      checkOutput({tag, ".valid"}, 32'(grantValidRr), 32'(expGrant != 4'b0000));
      checkOutput({tag, ".winner"}, 32'(winnerRr), 32'(expWinner));
      checkOutput({tag, ".terr"}, 32'(timeoutErrRr), 32'(expTerr));
   endtask

   // Compare every output of the fixed-priority instance.
   task automatic checkFp(input string tag, input logic [3:0] expGrant,
                          input logic [1:0] expWinner, input logic expTerr);
      checkOutput({tag, ".grant"}, 32'(grantFp), 32'(expGrant));
      checkOutput({tag, ".valid"}, 32'(grantValidFp), 32'(expGrant != 4'b0000));
      checkOutput({tag, ".winner"}, 32'(winnerFp), 32'(expWinner));
      checkOutput({tag, ".terr"}, 32'(timeoutErrFp), 32'(expTerr));
   endtask

   // Directed sequence.
   initial begin
      logic [3:0] expGrant;
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      applyStimulus(4'b0000, 1'b0, 4'b0000, 1'b0);

      #1;
      checkFp("resetFp", 4'b0000, 2'd0, 1'b0);
      checkRr("resetRr", 4'b0000, 2'd0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      nextCycle();
      checkRr("idleNoReq", 4'b0000, 2'd0, 1'b0);

      // Fixed priority: lowest set index wins, regrant after one idle cycle.
      applyStimulus(4'b1010, 1'b0, 4'b0000, 1'b0);
      nextCycle();
      checkFp("fpFirst", 4'b0010, 2'd1, 1'b0);
      applyStimulus(4'b1010, 1'b1, 4'b0000, 1'b0);
      nextCycle();
      applyStimulus(4'b1010, 1'b0, 4'b0000, 1'b0);
      checkFp("fpIdle", 4'b0000, 2'd1, 1'b0);
      nextCycle();
      checkFp("fpAgain", 4'b0010, 2'd1, 1'b0);
      applyStimulus(4'b1100, 1'b1, 4'b0000, 1'b0);
      nextCycle();
      nextCycle();
      checkFp("fpIdx2", 4'b0100, 2'd2, 1'b0);
      applyStimulus(4'b0000, 1'b0, 4'b0000, 1'b0);
      nextCycle();
      checkFp("fpWithdraw", 4'b0000, 2'd2, 1'b0);
      applyStimulus(4'b0000, 1'b1, 4'b0000, 1'b0);
      nextCycle();
      checkFp("fpAckIdle", 4'b0000, 2'd2, 1'b0);
      applyStimulus(4'b0000, 1'b0, 4'b0000, 1'b0);

      // Round-robin with all requests held: winners 0,1,2,3.
      applyStimulus(4'b0000, 1'b0, 4'b1111, 1'b0);
      for (int w = 0; w < 4; w++) begin
         nextCycle();
         expGrant = 4'b0001 << w;
         checkRr($sformatf("rrGrant%0d", w), expGrant, 2'(w), 1'b0);
         applyStimulus(4'b0000, 1'b0, 4'b1111, 1'b1);
         nextCycle();
         applyStimulus(4'b0000, 1'b0, (w == 3) ? 4'b0101 : 4'b1111, 1'b0);
         checkRr($sformatf("rrIdle%0d", w), 4'b0000, 2'(w), 1'b0);
      end

      // Wrap after winner 3: req 0101 gives 0 then 2.
      nextCycle();
      checkRr("wrapTo0", 4'b0001, 2'd0, 1'b0);
      applyStimulus(4'b0000, 1'b0, 4'b0101, 1'b1);
      nextCycle();
      applyStimulus(4'b0000, 1'b0, 4'b0101, 1'b0);
      nextCycle();
      checkRr("wrapThen2", 4'b0100, 2'd2, 1'b0);
      applyStimulus(4'b0000, 1'b0, 4'b0000, 1'b1);
      nextCycle();
      applyStimulus(4'b0000, 1'b0, 4'b0000, 1'b0);
      checkRr("wrapRelease", 4'b0000, 2'd2, 1'b0);

      // Timeout: req[2] alone (pointer is at 3), four grant cycles.
      applyStimulus(4'b0000, 1'b0, 4'b0100, 1'b0);
      nextCycle();
      for (int c = 1; c <= 4; c++) begin
         checkRr($sformatf("toHold%0d", c), 4'b0100, 2'd2, 1'b0);
         if (c == 4) applyStimulus(4'b0000, 1'b0, 4'b1100, 1'b0);
         nextCycle();
      end
      checkRr("toPulse", 4'b0000, 2'd2, 1'b1);
      nextCycle();
      checkRr("toNext3", 4'b1000, 2'd3, 1'b0);
      applyStimulus(4'b0000, 1'b0, 4'b0100, 1'b1);
      nextCycle();
      applyStimulus(4'b0000, 1'b0, 4'b0100, 1'b0);
      checkRr("ack3", 4'b0000, 2'd3, 1'b0);

      // ack_done in the fourth cycle wins over the timeout.
      nextCycle();
      for (int c = 1; c <= 4; c++) begin
         checkRr($sformatf("ackHold%0d", c), 4'b0100, 2'd2, 1'b0);
         if (c == 4) applyStimulus(4'b0000, 1'b0, 4'b0100, 1'b1);
         nextCycle();
      end
      applyStimulus(4'b0000, 1'b0, 4'b0100, 1'b0);
      checkRr("ackAtLimit", 4'b0000, 2'd2, 1'b0);

      // Only req[2] pending after a release from 2: it wins again.
      nextCycle();
      checkRr("toElse2", 4'b0100, 2'd2, 1'b0);
      nextCycle();
      nextCycle();
      nextCycle();
      nextCycle();
      checkRr("toPulse2", 4'b0000, 2'd2, 1'b1);
      nextCycle();
      checkRr("toOnePulse", 4'b0100, 2'd2, 1'b0);
      applyStimulus(4'b0000, 1'b0, 4'b0000, 1'b0);
      nextCycle();
      checkRr("dropReq2", 4'b0000, 2'd2, 1'b0);

      // Withdrawal by winner 1 in its second cycle; pointer becomes 2.
      applyStimulus(4'b0000, 1'b0, 4'b0010, 1'b0);
      nextCycle();
      checkRr("wdGrant", 4'b0010, 2'd1, 1'b0);
      nextCycle();
      applyStimulus(4'b0000, 1'b0, 4'b0000, 1'b0);
      checkRr("wdSecond", 4'b0010, 2'd1, 1'b0);
      nextCycle();
      checkRr("wdRelease", 4'b0000, 2'd1, 1'b0);
      applyStimulus(4'b0000, 1'b0, 4'b1111, 1'b0);
      nextCycle();
      checkRr("wdPtr2", 4'b0100, 2'd2, 1'b0);
      applyStimulus(4'b0000, 1'b0, 4'b1111, 1'b0);
      nextCycle();
      checkRr("otherReqNoEffect", 4'b0100, 2'd2, 1'b0);
      applyStimulus(4'b0000, 1'b0, 4'b1000, 1'b1);
      nextCycle();
      applyStimulus(4'b0000, 1'b0, 4'b1000, 1'b0);
      nextCycle();
      checkRr("grant3", 4'b1000, 2'd3, 1'b0);

      // Asynchronous reset in the middle of a grant.
      #3;
      rst_n = 1'b0;
      #1;
      checkRr("asyncReset", 4'b0000, 2'd0, 1'b0);
      #2;
      rst_n = 1'b1;
      nextCycle();
      checkRr("postReset", 4'b1000, 2'd3, 1'b0);
      applyStimulus(4'b0000, 1'b0, 4'b0000, 1'b0);
      nextCycle();
      checkRr("finalIdle", 4'b0000, 2'd3, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ack_bus_arbiter_rr.md
ACK_BUS_ARBITER_RR -- requirements
Module: ack_bus_arbiter_rr

Interface
Parameters:
REQ-001 The block SHALL have parameter NUM_SRC, default 4: number of ack sources; legal values are 2..16.
REQ-002 The block SHALL have parameter ID_W, default 2: winner ID width; it SHALL satisfy ID_W >= clog2(NUM_SRC).
REQ-003 The block SHALL have parameter RR_MODE, default 1: 1 = round-robin, 0 = fixed priority with index 0 highest.
REQ-004 The block SHALL have parameter TIMEOUT, default 16: maximum grant length in cycles before forced release; legal values are 2..255.

Ports:
REQ-005 clk  input  1  single clock; all state SHALL be updated on its rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 req  input  NUM_SRC  per-source ack request; bit i SHALL be held high until source i is granted.
REQ-008 ack_done  input  1  one-cycle pulse from the granted source marking end of its ack transfer.
REQ-009 grant  output  NUM_SRC  registered one-hot ready to the winning source.
REQ-010 grant_valid  output  1  high while any grant bit is high.
REQ-011 winner_id  output  ID_W  index of the granted source, broadcast to all sources.
REQ-012 timeout_err  output  1  one-cycle pulse on forced release.

Function
REQ-013 The FSM SHALL have exactly 2 states: IDLE and GRANT.
REQ-014 In IDLE with req != 0 at a rising edge, the FSM SHALL enter GRANT on that edge.
- grant SHALL be a registered one-hot output; winner_id SHALL equal the winner's index.
- Latency from req sampled to grant visible SHALL be 1 cycle.
REQ-015 In IDLE with req == 0, the FSM SHALL stay in IDLE with grant = 0.
REQ-016 With RR_MODE = 0, the winner SHALL be the lowest set index of req.
REQ-017 With RR_MODE = 1, the winner SHALL be the first set bit of req at or above rr_ptr, searching upward with wrap-around.
- rr_ptr SHALL be an internal ID_W-bit register.
REQ-018 On every release, rr_ptr SHALL load (winner_id + 1) mod NUM_SRC; on wrap from NUM_SRC-1, rr_ptr SHALL load 0.
REQ-019 In GRANT, grant and winner_id SHALL hold stable until a release.
- Requests from other sources SHALL NOT change grant or winner_id.
REQ-020 Release conditions in GRANT, checked in priority order:
- (a) ack_done = 1.
- (b) req[winner_id] = 0, i.e. the source withdrew.
- (c) Timeout counter = TIMEOUT-1.
REQ-021 On any release, the FSM SHALL return to IDLE, and grant and grant_valid SHALL be 0 for at least one cycle.
- Back-to-back grants SHALL therefore be separated by exactly 1 idle cycle when requests are pending.
REQ-022 The timeout counter SHALL clear on entry to GRANT and increment each GRANT cycle.
- Its width SHALL be 8 bits; it SHALL NOT wrap, because release occurs first.
REQ-023 timeout_err SHALL pulse for one cycle, coincident with the first IDLE cycle, only on release cause (c).
REQ-024 If ack_done and the timeout hit occur in the same cycle, the release SHALL be a normal release with no timeout_err.
REQ-025 ack_done while in IDLE SHALL be ignored and SHALL have no state effect.
REQ-026 After a release, winner_id SHALL retain its last value and SHALL be valid only when grant_valid = 1.
REQ-027 grant SHALL never have more than one bit set.
REQ-028 grant_valid SHALL always equal the OR of all grant bits.

Reset
REQ-029 When rst_n = 0, the block SHALL immediately, without waiting for a clock edge:
- set state = IDLE, grant = 0, grant_valid = 0, winner_id = 0, timeout_err = 0, rr_ptr = 0 and the timeout counter = 0.
REQ-030 Reset asserted mid-GRANT SHALL drop grant asynchronously, and no timeout_err SHALL be produced.
REQ-031 After rst_n rises, the first arbitration SHALL occur at the first rising edge with req != 0.

Verification
Default parameters unless noted.
REQ-032 Fixed priority, RR_MODE = 0, req = 4'b1010 held -> grant = 4'b0010, winner_id = 1 at cycle +1.
- Continued: ack_done -> idle 1 cycle, then grant = 4'b0010 again.
REQ-033 Round-robin, req = 4'b1111 held, ack_done pulsed 1 cycle after each grant -> winner sequence 0,1,2,3,0, each grant 1 cycle, 1 idle cycle between grants.
REQ-034 Round-robin wrap: last winner 3, then req = 4'b0101 -> winner_id = 0; next winner 2.
REQ-035 Timeout, TIMEOUT = 4: req[2] held, no ack_done -> grant = 4'b0100 for exactly 4 cycles, then timeout_err = 1 for 1 cycle.
- Continued: the next grant goes to index 3 if req[3] is set, else to index 2.
- Variant: ack_done in the 4th cycle -> no timeout_err.
REQ-036 Withdrawal: winner 1 drops req[1] in the 2nd GRANT cycle -> grant = 0 in the next cycle, timeout_err = 0, rr_ptr = 2.
REQ-037 Async reset: rst_n pulled low mid-GRANT between clock edges -> all outputs 0 before the next edge.
- Continued: after release with req = 4'b1000 -> grant = 4'b1000 one cycle later.
